// File: rtl/sobel_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_ctrl
// Sobel edge-detection stage. It sits between the UART byte receiver and the
// VGA picture RAM writer. It takes a raster stream of COL_MAX x ROW_MAX 8-bit
// grayscale pixels and produces one result per interior pixel. That is
// (COL_MAX-2) x (ROW_MAX-2) results per frame, in raster order, with a fixed
// latency of 3 cycles.
//
// Ports:
//   sys_clk    in   1  system clock, rising edge
//   sys_rst_n  in   1  asynchronous active-low reset
//   pi_data    in   8  grayscale input pixel
//   pi_flag    in   1  pi_data valid, one pixel per high cycle
//   po_data    out  8  result pixel, held between results
//   po_flag    out  1  one-cycle pulse per result
//
// Build option:
//   SOBEL_RAW_MAG_EN  when defined, po_data is |Gx|+|Gy| saturated to 8 bits
//                     and THRESHOLD is unused. When undefined (the default),
//                     po_data is 8'h00 for an edge (gxy >= THRESHOLD) and
//                     8'hFF otherwise.
// -----------------------------------------------------------------------------
module sobel_ctrl #(
    parameter int         COL_MAX   = 100,
    parameter int         ROW_MAX   = 100,
    parameter logic [10:0] THRESHOLD = 11'd12
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic [7:0] po_data,
    output logic       po_flag
);

    localparam int CW = (COL_MAX > 1) ? $clog2(COL_MAX) : 1;
    localparam int RW = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;

    // ------------------------------------------------------------------
    // Raster position of the pixel currently on pi_data
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_col_q, cnt_col_d;
    logic [RW-1:0] cnt_row_q, cnt_row_d;

    always_comb begin
        cnt_col_d = cnt_col_q;
        cnt_row_d = cnt_row_q;
        if (pi_flag) begin
            if (cnt_col_q == CW'(COL_MAX - 1)) begin
                cnt_col_d = '0;
                cnt_row_d = (cnt_row_q == RW'(ROW_MAX - 1)) ? '0 : cnt_row_q + RW'(1);
            end else begin
                cnt_col_d = cnt_col_q + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: l1 holds row r-2 and l2 holds row r-1. Each column slot
    // is read and rewritten in the same cycle, so the stored rows slide down
    // by one without any separate copy pass. The contents need no reset.
    // ------------------------------------------------------------------
    logic [7:0] l1_mem [COL_MAX];
    logic [7:0] l2_mem [COL_MAX];
    logic [7:0] l1_rd;
    logic [7:0] l2_rd;

    assign l1_rd = l1_mem[cnt_col_q];
    assign l2_rd = l2_mem[cnt_col_q];

    always_ff @(posedge sys_clk) begin
        if (pi_flag) begin
            l1_mem[cnt_col_q] <= l2_rd;
            l2_mem[cnt_col_q] <= pi_data;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: 3x3 window. a = top row, b = middle row, c = bottom row.
    // Index 2 is the newest column.
    // ------------------------------------------------------------------
    logic [7:0] a0_q, a1_q, a2_q, b0_q, b1_q, b2_q, c0_q, c1_q, c2_q;
    logic [7:0] a0_d, a1_d, a2_d, b0_d, b1_d, b2_d, c0_d, c1_d, c2_d;
    logic       win_vld_q, win_vld_d;

    always_comb begin
        a0_d = a0_q; a1_d = a1_q; a2_d = a2_q;
        b0_d = b0_q; b1_d = b1_q; b2_d = b2_q;
        c0_d = c0_q; c1_d = c1_q; c2_d = c2_q;
        win_vld_d = 1'b0;
        if (pi_flag) begin
            a0_d = a1_q; a1_d = a2_q; a2_d = l1_rd;
            b0_d = b1_q; b1_d = b2_q; b2_d = l2_rd;
            c0_d = c1_q; c1_d = c2_q; c2_d = pi_data;
            // The window is complete once two earlier rows and two earlier
            // columns exist. It is then centred on (row-1, col-1).
            win_vld_d = (cnt_row_q >= RW'(2)) && (cnt_col_q >= CW'(2));
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: signed gradients. Each weighted sum is at most 1020, so an
    // 11-bit modular difference is the exact two's-complement result.
    // ------------------------------------------------------------------
    logic [10:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx_q, gx_d, gy_q, gy_d;
    logic               grad_vld_q, grad_vld_d;

    always_comb begin
        gx_pos = {3'b000, a2_q} + {2'b00, b2_q, 1'b0} + {3'b000, c2_q};
        gx_neg = {3'b000, a0_q} + {2'b00, b0_q, 1'b0} + {3'b000, c0_q};
        gy_pos = {3'b000, c0_q} + {2'b00, c1_q, 1'b0} + {3'b000, c2_q};
        gy_neg = {3'b000, a0_q} + {2'b00, a1_q, 1'b0} + {3'b000, a2_q};
        gx_d = gx_q;
        gy_d = gy_q;
        grad_vld_d = win_vld_q;
        if (win_vld_q) begin
            gx_d = signed'(gx_pos - gx_neg);
            gy_d = signed'(gy_pos - gy_neg);
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: magnitude and output mapping
    // ------------------------------------------------------------------
    logic [10:0] gx_abs, gy_abs, gxy;
    logic [7:0]  po_data_q, po_data_d;
    logic        po_flag_q, po_flag_d;

    always_comb begin
        gx_abs = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
        gy_abs = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
        gxy = gx_abs + gy_abs;
        po_data_d = po_data_q;
        po_flag_d = grad_vld_q;
        if (grad_vld_q) begin
`ifdef SOBEL_RAW_MAG_EN
            po_data_d = (gxy > 11'd255) ? 8'hFF : gxy[7:0];
`else
            po_data_d = (gxy >= THRESHOLD) ? 8'h00 : 8'hFF;
`endif
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_col_q  <= '0;
            cnt_row_q  <= '0;
            a0_q <= '0; a1_q <= '0; a2_q <= '0;
            b0_q <= '0; b1_q <= '0; b2_q <= '0;
            c0_q <= '0; c1_q <= '0; c2_q <= '0;
            win_vld_q  <= 1'b0;
            gx_q       <= '0;
            gy_q       <= '0;
            grad_vld_q <= 1'b0;
            po_data_q  <= 8'h00;
            po_flag_q  <= 1'b0;
        end else begin
            cnt_col_q  <= cnt_col_d;
            cnt_row_q  <= cnt_row_d;
            a0_q <= a0_d; a1_q <= a1_d; a2_q <= a2_d;
            b0_q <= b0_d; b1_q <= b1_d; b2_q <= b2_d;
            c0_q <= c0_d; c1_q <= c1_d; c2_q <= c2_d;
            win_vld_q  <= win_vld_d;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            grad_vld_q <= grad_vld_d;
            po_data_q  <= po_data_d;
            po_flag_q  <= po_flag_d;
        end
    end

    assign po_data = po_data_q;
    assign po_flag = po_flag_q;

endmodule

// File: tb/tb_sobel_ctrl.sv
module tb_sobel_ctrl;

    localparam int NCOL = 100;
    localparam int NROW = 100;
    localparam int NOUT = (NCOL - 2) * (NROW - 2);

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] pi_data = 8'h00;
    logic       pi_flag = 1'b0;
    logic [7:0] po_data;
    logic       po_flag;

    sobel_ctrl dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .pi_data  (pi_data),
        .pi_flag  (pi_flag),
        .po_data  (po_data),
        .po_flag  (po_flag)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   out_cnt = 0;

    // Image patterns: 0 uniform, 1 vertical step, 2 horizontal step (00/10),
    // 3 small-amplitude texture with gradients close to the threshold.
    function automatic int pix(input int kind, input int r, input int c);
        case (kind)
            0:       return 128;
            1:       return (c < 50) ? 0 : 255;
            2:       return (r < 50) ? 0 : 16;
            3:       return (r * 37 + c * 11 + r * c) % 7;
            default: return 0;
        endcase
    endfunction

    // Reference Sobel result for the window whose newest pixel is (r, c).
    function automatic logic [7:0] exp_sobel(input int kind, input int r, input int c);
        int p[3][3];
        int gx, gy, mag;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = pix(kind, r - 2 + i, c - 2 + j);
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag >= 12) ? 8'h00 : 8'hFF;
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Output monitor: every po_flag must match the head of the scoreboard
    // in both data and arrival cycle.
    always @(negedge sys_clk) begin
        exp_t e;
        if (sys_rst_n && po_flag === 1'b1) begin
            out_cnt++;
            check("unexpected_output", (sb_q.size() > 0) ? 1 : 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("po_data", int'(po_data), int'(e.data));
                check("po_latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive_pix(input int kind, input int r, input int c);
        @(posedge sys_clk);
        #1;
        pi_flag = 1'b1;
        pi_data = 8'(pix(kind, r, c));
        if (r >= 2 && c >= 2) sb_q.push_back('{exp_sobel(kind, r, c), cyc + 3});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            pi_flag = 1'b0;
        end
    endtask

    // Rows below sparse_rows use one valid cycle in every ten.
    task automatic send_rows(input int kind, input int r0, input int r1, input int sparse_rows);
        for (int r = r0; r <= r1; r++)
            for (int c = 0; c < NCOL; c++) begin
                drive_pix(kind, r, c);
                if (r < sparse_rows) idle(9);
            end
    endtask

    task automatic drain(input string tag);
        int b = 0;
        idle(1);
        while (sb_q.size() != 0 && b < 50) begin
            @(negedge sys_clk);
            b++;
        end
        check(tag, sb_q.size(), 0);
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int start;

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_po_flag", int'(po_flag), 0);
        check("reset_po_data", int'(po_data), 0);
        sys_rst_n = 1'b1;
        idle(2);

        // Two back-to-back frames: uniform, then texture
        start = out_cnt;
        send_rows(0, 0, NROW - 1, 0);
        send_rows(3, 0, 1, 0);
        check("frame1_count", out_cnt - start, NOUT);
        send_rows(3, 2, NROW - 1, 0);
        drain("frame2_drain");
        check("frame12_count", out_cnt - start, 2 * NOUT);

        // Vertical step
        start = out_cnt;
        send_rows(1, 0, NROW - 1, 0);
        drain("vstep_drain");
        check("vstep_count", out_cnt - start, NOUT);

        // Horizontal step
        start = out_cnt;
        send_rows(2, 0, NROW - 1, 0);
        drain("hstep_drain");
        check("hstep_count", out_cnt - start, NOUT);

        // Sparse input for the first three rows, uniform frame
        start = out_cnt;
        send_rows(0, 0, NROW - 1, 3);
        drain("sparse_drain");
        check("sparse_count", out_cnt - start, NOUT);

        // Reset in the middle of row 50 while results are streaming
        send_rows(3, 0, 49, 0);
        for (int c = 0; c < 37; c++) drive_pix(3, 50, c);
        #2;
        check("pre_reset_po_flag", int'(po_flag), 1);
        sys_rst_n = 1'b0;
        pi_flag = 1'b0;
        #1;
        check("async_reset_po_flag", int'(po_flag), 0);
        check("async_reset_po_data", int'(po_data), 0);
        sb_q.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        start = out_cnt;
        send_rows(3, 0, NROW - 1, 0);
        drain("post_reset_drain");
        check("post_reset_count", out_cnt - start, NOUT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
